// File: rtl/CPU_buffer_bus.sv
// CPU_buffer_bus: pipeline-buffer payload types and fetch FSM encoding shared by IF and IF2ID.
package CPU_buffer_bus;
  localparam int BUS_XLEN = 32;
  localparam logic [BUS_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [BUS_XLEN-1:0] pc;
    logic [BUS_XLEN-1:0] pc_plus4;
    logic [BUS_XLEN-1:0] inst;
  } if_id_bus_t;
  typedef struct packed {
    logic       valid;
    if_id_bus_t payload;
  } tracer_bus_t;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_e;
endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: single-outstanding instruction fetch with stall hold and redirect/drop handling.
module if_fetch_unit
  import CPU_buffer_bus::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            ACLK,
  input  logic            ARESET,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            stall_en,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output if_id_bus_t      if_id_bus_out,
  output logic            fetch_busy
`ifdef TRACE
  ,
  output tracer_bus_t     trace_bus
`endif
);
  fetch_state_e    state, state_d;
  logic [XLEN-1:0] pc, pc_d, hold_inst, hold_d, pc_plus4, target;
  logic            drop, drop_d;
  assign pc_plus4      = pc + XLEN'(4);
  assign target        = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_req_addr = pc;
  always_comb begin
    state_d        = state;
    pc_d           = pc;
    drop_d         = drop;
    hold_d         = hold_inst;
    imem_req_valid = 1'b0;
    fetch_busy     = 1'b0;
    if_id_bus_out  = '0;
    case (state)
      REQ: begin
        imem_req_valid = 1'b1;
        pc_d           = redirect_en ? target : pc;
        drop_d         = redirect_en && imem_req_ready;
        state_d        = imem_req_ready ? WAIT : REQ;
      end
      WAIT: begin
        fetch_busy = 1'b1;
        if (imem_resp_valid) begin
          drop_d = 1'b0;
          if (redirect_en) begin
            pc_d    = target;
            state_d = REQ;
          end else if (drop) begin
            state_d = REQ;
          end else if (!stall_en) begin
            if_id_bus_out = '{pc: pc, pc_plus4: pc_plus4, inst: imem_resp_data};
            pc_d          = pc_plus4;
            state_d       = REQ;
          end else begin
            hold_d  = imem_resp_data;
            state_d = HOLD;
          end
        end else if (redirect_en) begin
          pc_d   = target;
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if_id_bus_out = redirect_en ? '0 : '{pc: pc, pc_plus4: pc_plus4, inst: hold_inst};
        pc_d          = redirect_en ? target : (stall_en ? pc : pc_plus4);
        state_d       = (redirect_en || !stall_en) ? REQ : HOLD;
      end
      default: state_d = REQ;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= REQ;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      hold_inst <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      drop      <= drop_d;
      hold_inst <= hold_d;
    end
  end
`ifdef TRACE
  assign trace_bus = '{valid: if_id_bus_out != '0, payload: if_id_bus_out};
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed cycle-by-cycle vectors for the fetch unit with hand-computed expectations.
module tb_if_fetch_unit;
  import CPU_buffer_bus::*;
  logic        ACLK = 1'b0;
  logic        ARESET, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic        stall_en, redirect_en, fetch_busy;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc;
  if_id_bus_t  if_id_bus_out;
  int          checks = 0, errors = 0;
  always #5 ACLK = ~ACLK;
  if_fetch_unit dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .stall_en(stall_en), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .if_id_bus_out(if_id_bus_out), .fetch_busy(fetch_busy)
  );
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge ACLK);
    #1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_en     = 1'b0;
    redirect_pc     = '0;
  endtask
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd, input logic st,
                       input logic re, input logic [31:0] rp);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    stall_en        = st;
    redirect_en     = re;
    redirect_pc     = rp;
    #1;
  endtask
  initial begin
    ARESET = 1'b1;
    stall_en = 1'b0;
    tick();
    tick();
    ARESET = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    check("rst_req_valid", 96'(imem_req_valid), 96'd1);
    check("rst_addr", 96'(imem_req_addr), 96'h0);
    check("rst_bus", if_id_bus_out, 96'h0);
    check("rst_busy", 96'(fetch_busy), 96'd0);
    tick();
    drive(0, 1, 32'hD000_0000, 0, 0, 0);
    check("w0_busy", 96'(fetch_busy), 96'd1);
    check("w0_req_valid", 96'(imem_req_valid), 96'd0);
    check("bus_d0", if_id_bus_out, {32'h0, 32'h4, 32'hD000_0000});
    tick();
    drive(1, 0, 0, 0, 0, 0);
    check("addr_4", 96'(imem_req_addr), 96'h4);
    check("bubble_req4", if_id_bus_out, 96'h0);
    tick();
    drive(0, 1, 32'hD000_0001, 0, 0, 0);
    check("bus_d1", if_id_bus_out, {32'h4, 32'h8, 32'hD000_0001});
    tick();
    drive(1, 0, 0, 0, 0, 0);
    check("addr_8", 96'(imem_req_addr), 96'h8);
    tick();
    drive(0, 1, 32'hD000_0002, 1, 0, 0);
    check("stall_resp_bubble", if_id_bus_out, 96'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, i < 2, 0, 0);
      check($sformatf("hold_bus%0d", i), if_id_bus_out, {32'h8, 32'hC, 32'hD000_0002});
      check($sformatf("hold_noreq%0d", i), 96'(imem_req_valid), 96'd0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0);
    check("after_hold_valid", 96'(imem_req_valid), 96'd1);
    check("after_hold_addr", 96'(imem_req_addr), 96'hC);
    tick();
    drive(0, 0, 0, 0, 1, 32'h100);
    check("redir_wait_busy", 96'(fetch_busy), 96'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("drop_busy", 96'(fetch_busy), 96'd1);
    check("drop_noreq", 96'(imem_req_valid), 96'd0);
    tick();
    drive(0, 1, 32'hD000_0003, 0, 0, 0);
    check("dropped_bus", if_id_bus_out, 96'h0);
    check("dropped_busy", 96'(fetch_busy), 96'd1);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    check("redir_addr_100", 96'(imem_req_addr), 96'h100);
    check("redir_busy_lo", 96'(fetch_busy), 96'd0);
    tick();
    drive(0, 1, 32'hD000_0004, 0, 1, 32'h203);
    check("redir_resp_bus", if_id_bus_out, 96'h0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    check("redir_masked_addr", 96'(imem_req_addr), 96'h200);
    tick();
    drive(0, 1, 32'hD000_0005, 1, 0, 0);
    tick();
    drive(0, 0, 0, 1, 1, 32'h300);
    tick();
    drive(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    check("hold_redir_valid", 96'(imem_req_valid), 96'd1);
    check("hold_redir_addr", 96'(imem_req_addr), 96'h300);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    check("req_redir_addr", 96'(imem_req_addr), 96'hFFFF_FFFC);
    tick();
    drive(0, 1, 32'hD000_0006, 0, 0, 0);
    check("wrap_bus", if_id_bus_out, {32'hFFFF_FFFC, 32'h0, 32'hD000_0006});
    tick();
    drive(1, 0, 0, 0, 1, 32'h40);
    check("wrap_addr", 96'(imem_req_addr), 96'h0);
    tick();
    drive(0, 1, 32'hD000_0007, 0, 0, 0);
    check("accept_redir_drop", if_id_bus_out, 96'h0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    check("accept_redir_addr", 96'(imem_req_addr), 96'h40);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("pre_rst_busy", 96'(fetch_busy), 96'd1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check("midrst_valid", 96'(imem_req_valid), 96'd1);
    check("midrst_addr", 96'(imem_req_addr), 96'h0);
    check("midrst_bus", if_id_bus_out, 96'h0);
    check("midrst_busy", 96'(fetch_busy), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Owns the PC, issues single-outstanding requests to instruction memory, and produces the `if_id_bus_t` payload that IF2ID latches.
- Honours the same `stall_en` that freezes IF2ID.
- Absorbs a branch/jump redirect at any point of a fetch transaction. Stale responses are discarded, never forwarded.
- Presents an all-zero bubble whenever no valid instruction is available.

Parameters:
- `XLEN`, 32, address/instruction width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `ACLK`  in  1  clock.
- `ARESET`  in  1  reset; synchronous, active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_req_addr`  out  XLEN  fetch address (word aligned).
- `imem_resp_valid`  in  1  read data valid; exactly one per accepted request, earliest the cycle after accept.
- `imem_resp_data`  in  XLEN  instruction word.
- `stall_en`  in  1  IF2ID holding; payload not consumed this cycle.
- `redirect_en`  in  1  control-flow redirect pulse from EX.
- `redirect_pc`  in  XLEN  redirect target.
- `if_id_bus_out`  out  `if_id_bus_t`  payload to IF2ID input.
- `fetch_busy`  out  1  a request is outstanding (for hazard unit/debug).

Behaviour:
- Registers: `pc`, `state` {REQ, WAIT, HOLD}, `drop` (1b), `hold_inst` (XLEN).
- Reset (`ARESET`=1 at posedge) gives: `pc`=RESET_PC, `state`=REQ, `drop`=0, `hold_inst`=0. Combinational outputs from that state: `imem_req_valid`=1, `imem_req_addr`=RESET_PC, `if_id_bus_out`='0, `fetch_busy`=0.
- Reset mid-transaction abandons the outstanding request. Memory is reset on the same `ARESET`, so no late response arrives.
- REQ:
  - `imem_req_valid`=1, `imem_req_addr`=`pc`, bus='0.
  - `imem_req_ready`=1 → WAIT.
  - The memory side tolerates the address changing while valid is held; there is no stability rule.
- WAIT:
  - `fetch_busy`=1, `imem_req_valid`=0.
  - On `imem_resp_valid` with `drop`=1: discard the response, clear `drop`, → REQ (`pc` already holds the redirect target).
  - On `imem_resp_valid` with `drop`=0 and `stall_en`=0: bus = {pc=`pc`, pc_plus4=`pc`+4, inst=`imem_resp_data`} combinationally, same cycle. Then `pc`←`pc`+4, → REQ.
  - On `imem_resp_valid` with `drop`=0 and `stall_en`=1: `hold_inst`←`imem_resp_data`, → HOLD. Bus='0 this cycle; IF2ID is stalled and ignores it.
  - No response: bus='0, remain in WAIT.
- HOLD:
  - Bus = {`pc`, `pc`+4, `hold_inst`}, no request issued.
  - `stall_en`=0: payload consumed, `pc`←`pc`+4, → REQ.
- Redirect (`redirect_en`=1) has priority over stall and normal progress, in every state:
  - REQ, not accepted: `pc`←`redirect_pc`, stay in REQ. Address follows next cycle.
  - REQ, accepted same cycle: `pc`←`redirect_pc`, `drop`←1, → WAIT.
  - WAIT, no response: `pc`←`redirect_pc`, `drop`←1.
  - WAIT, response same cycle: response dropped, bus='0, `pc`←`redirect_pc`, → REQ.
  - HOLD: `hold_inst` discarded, `pc`←`redirect_pc`, → REQ.
  - A second redirect while `drop`=1 only updates `pc`. At most one response is ever outstanding.
- Arithmetic: `pc`+4 wraps modulo 2^XLEN (32'hFFFF_FFFC → 0). `redirect_pc[1:0]` is ignored (forced 0).
- Steady-state throughput with 1-cycle memory latency is one instruction per 2 cycles (single outstanding request by design).

Decomposition:
- `CPU_buffer_bus` package owns `if_id_bus_t` with fields `pc`, `pc_plus4`, `inst`. Bubble = '0.
- The same package holds `fetch_state_e` (REQ/WAIT/HOLD) and `RESET_PC_DEFAULT`.
- No sub-module. The FSM and PC datapath stay in one file. The `TRACE` build additionally drives `tracer_bus_t` with the same timing as `if_id_bus_out`.

Test Plan:
- Reset release, memory always ready, latency 1 → request addrs 0x0, 0x4, 0x8; bus carries pc=0x0/inst=D0 on its resp cycle, then 0x4/D1; '0 between.
- Response at addr 0x8 while `stall_en`=1 for 3 cycles → state HOLD, bus holds {0x8, 0xC, D2} all 3 cycles; next request at 0xC only after `stall_en` drops.
- `redirect_en` with target 0x100 in WAIT, response arrives 2 cycles later → response never appears on bus; next request addr 0x100; `fetch_busy` high until the dropped response.
- `redirect_en` same cycle as `imem_resp_valid` → bus='0 that cycle, next request 0x100.
- `redirect_en` during HOLD while `stall_en`=1 → held inst discarded, request to target issued next cycle despite stall.
- `pc`=0xFFFF_FFFC fetch completes → next request addr 0x0000_0000. Assert `ARESET` mid-WAIT → next cycle requests RESET_PC, bus='0.
